oldland_regfile_dbg: RTL and testbench

OLDLAND_REGFILE_DBG -- requirements
Module: oldland_regfile_dbg

---
 rtl/oldland_regfile_dbg.sv | 112 +++++++++++
 tb/tb_oldland_regfile_dbg.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oldland_regfile_dbg.sv
// Register file with two registered read ports, one core write port and a
// single-outstanding debug access port; all registers are zeroed after reset.
module oldland_regfile_dbg #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 8,
   parameter int SEL_WIDTH  = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [SEL_WIDTH-1:0]  ra_sel,
   input  logic [SEL_WIDTH-1:0]  rb_sel,
   input  logic [SEL_WIDTH-1:0]  rd_sel,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_val,
   output logic [DATA_WIDTH-1:0] ra,
   output logic [DATA_WIDTH-1:0] rb,
   output logic                  busy,
   input  logic                  dbg_req,
   input  logic                  dbg_wr,
   input  logic [SEL_WIDTH-1:0]  dbg_sel,
   input  logic [DATA_WIDTH-1:0] dbg_wr_val,
   output logic [DATA_WIDTH-1:0] dbg_rd_val,
   output logic                  dbg_ack,
   output logic [1:0]            fsm_state
);

   if (NUM_REGS < 2 || (NUM_REGS & (NUM_REGS - 1)) != 0 || SEL_WIDTH != $clog2(NUM_REGS)) begin : g_bad_params
      $error("oldland_regfile_dbg: NUM_REGS must be a power of two >= 2 and SEL_WIDTH == log2(NUM_REGS)");
   end

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_RUN   = 2'd1,
      ST_ACK   = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [SEL_WIDTH-1:0]    r_clr_cnt;
   logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];
   logic [DATA_WIDTH-1:0]   r_ra;
   logic [DATA_WIDTH-1:0]   r_rb;
   logic [DATA_WIDTH-1:0]   r_dbg_rd_val;
   logic                    w_active;
   logic                    w_dbg_accept;
   logic                    w_dbg_commit;
   logic                    w_clr_last;
   logic [DATA_WIDTH-1:0]   w_ra_next;
   logic [DATA_WIDTH-1:0]   w_rb_next;
   logic [DATA_WIDTH-1:0]   w_dbg_rd_next;

   assign w_active     = (r_state != ST_CLEAR);
   assign w_dbg_accept = (r_state == ST_RUN) && dbg_req;
   // A core write to the same register wins; the debug write is dropped but still acked.
   assign w_dbg_commit = w_dbg_accept && dbg_wr && !(wr_en && (rd_sel == dbg_sel));
   assign w_clr_last   = (r_clr_cnt == SEL_WIDTH'(NUM_REGS - 1));

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_CLEAR: if (w_clr_last) w_state_next = ST_RUN;
         ST_RUN:   if (dbg_req) w_state_next = ST_ACK;
         ST_ACK:   w_state_next = ST_RUN;
         default:  w_state_next = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_CLEAR;
      else     r_state <= w_state_next;
   end

   // Read ports see the value being written at the same edge.
   always_comb begin
      w_ra_next = r_regs[ra_sel];
      if (w_dbg_commit && (dbg_sel == ra_sel)) w_ra_next = dbg_wr_val;
      if (wr_en && (rd_sel == ra_sel))         w_ra_next = wr_val;
      w_rb_next = r_regs[rb_sel];
      if (w_dbg_commit && (dbg_sel == rb_sel)) w_rb_next = dbg_wr_val;
      if (wr_en && (rd_sel == rb_sel))         w_rb_next = wr_val;
      w_dbg_rd_next = r_regs[dbg_sel];
      if (wr_en && (rd_sel == dbg_sel))        w_dbg_rd_next = wr_val;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_clr_cnt    <= '0;
         r_ra         <= '0;
         r_rb         <= '0;
         r_dbg_rd_val <= '0;
      end else if (!w_active) begin
         r_regs[r_clr_cnt] <= '0;
         r_clr_cnt         <= r_clr_cnt + SEL_WIDTH'(1);
         r_ra              <= '0;
         r_rb              <= '0;
      end else begin
         if (w_dbg_commit) r_regs[dbg_sel] <= dbg_wr_val;
         if (wr_en)        r_regs[rd_sel]  <= wr_val;
         r_ra <= w_ra_next;
         r_rb <= w_rb_next;
         if (w_dbg_accept && !dbg_wr) r_dbg_rd_val <= w_dbg_rd_next;
      end
   end

   assign ra         = r_ra;
   assign rb         = r_rb;
   assign busy       = (r_state == ST_CLEAR);
   assign dbg_ack    = (r_state == ST_ACK);
   assign dbg_rd_val = r_dbg_rd_val;
   assign fsm_state  = r_state;

endmodule

// File: tb/tb_oldland_regfile_dbg.sv
// Bench for oldland_regfile_dbg: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model of the register file.
module tb_oldland_regfile_dbg;

   localparam int W = 32;
   localparam int N = 8;
   localparam int S = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic [S-1:0] ra_sel, rb_sel, rd_sel, dbg_sel;
   logic         wr_en, dbg_req, dbg_wr;
   logic [W-1:0] wr_val, dbg_wr_val;
   logic [W-1:0] ra, rb, dbg_rd_val;
   logic         busy, dbg_ack;
   logic [1:0]   fsm_state;

   logic         rst16;
   logic [3:0]   sel16;
   logic [W-1:0] ra16, rb16, rd16;
   logic         busy16, ack16;
   logic [1:0]   st16;

   int total = 0;
   int bad   = 0;

   // behavioural model state
   logic [W-1:0] m_mem [N];
   int           m_busy_left;
   bit           m_ack;
   logic [W-1:0] m_ra, m_rb, m_rd;
   bit           m_rd_valid;

   always #5 clk = ~clk;

   oldland_regfile_dbg #(.DATA_WIDTH(W), .NUM_REGS(N), .SEL_WIDTH(S)) dut (
      .clk(clk), .rst(rst), .ra_sel(ra_sel), .rb_sel(rb_sel), .rd_sel(rd_sel),
      .wr_en(wr_en), .wr_val(wr_val), .ra(ra), .rb(rb), .busy(busy),
      .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_sel(dbg_sel), .dbg_wr_val(dbg_wr_val),
      .dbg_rd_val(dbg_rd_val), .dbg_ack(dbg_ack), .fsm_state(fsm_state)
   );

   oldland_regfile_dbg #(.DATA_WIDTH(W), .NUM_REGS(16), .SEL_WIDTH(4)) dut16 (
      .clk(clk), .rst(rst16), .ra_sel(sel16), .rb_sel(sel16), .rd_sel(sel16),
      .wr_en(1'b0), .wr_val('0), .ra(ra16), .rb(rb16), .busy(busy16),
      .dbg_req(1'b0), .dbg_wr(1'b0), .dbg_sel(sel16), .dbg_wr_val('0),
      .dbg_rd_val(rd16), .dbg_ack(ack16), .fsm_state(st16)
   );

   task automatic set_idle();
      rst = 1'b0; wr_en = 1'b0; dbg_req = 1'b0; dbg_wr = 1'b0;
      ra_sel = '0; rb_sel = '0; rd_sel = '0; dbg_sel = '0;
      wr_val = '0; dbg_wr_val = '0;
   endtask

   // Advance the model by one edge from the current inputs, then let the clock edge happen.
   task automatic model_edge();
      logic [W-1:0] nx [N];
      bit acc;
      if (rst) begin
         m_busy_left = N; m_ack = 0; m_ra = '0; m_rb = '0; m_rd = '0; m_rd_valid = 1;
      end else if (m_busy_left > 0) begin
         m_mem[N - m_busy_left] = '0;
         m_busy_left--;
         m_ra = '0; m_rb = '0; m_ack = 0;
      end else begin
         nx = m_mem;
         acc = dbg_req && !m_ack;
         if (acc && dbg_wr) nx[dbg_sel] = dbg_wr_val;
         if (wr_en)         nx[rd_sel]  = wr_val;
         m_ra = nx[ra_sel];
         m_rb = nx[rb_sel];
         if (acc && !dbg_wr) begin m_rd = nx[dbg_sel]; m_rd_valid = 1; end
         if (acc && dbg_wr)  m_rd_valid = 0;
         m_ack = acc;
         m_mem = nx;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      int n;
      set_idle();
      rst = 1'b1;
      model_edge();
      rst = 1'b0;
      total++;
      if (ra !== '0 || rb !== '0 || dbg_ack !== 1'b0 || dbg_rd_val !== '0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL reset_state: ra=%h rb=%h ack=%b rd=%h busy=%b, required 0 0 0 0 1",
                  ra, rb, dbg_ack, dbg_rd_val, busy);
      end
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         wr_en = 1'b1; rd_sel = S'($urandom_range(N - 1)); wr_val = $urandom;
         dbg_req = 1'b1; dbg_wr = 1'b1; dbg_sel = rd_sel; dbg_wr_val = $urandom;
         model_edge();
         total++;
         if (dbg_ack !== 1'b0 || ra !== '0 || rb !== '0) begin
            bad++;
            $display("FAIL clear_outputs: ack=%b ra=%h rb=%h, required 0 0 0", dbg_ack, ra, rb);
         end
      end
      set_idle();
      total++;
      if (n != N) begin
         bad++;
         $display("FAIL clear_busy_cycles: got %0d, required %0d", n, N);
      end
      for (int i = 0; i < N; i++) begin
         ra_sel = S'(i); rb_sel = S'(N - 1 - i);
         model_edge();
         total++;
         if (ra !== '0 || rb !== '0) begin
            bad++;
            $display("FAIL clear_contents: ra=%h rb=%h, required 0 0", ra, rb);
         end
      end
   endtask

   task automatic test_write_read();
      set_idle();
      wr_en = 1'b1; rd_sel = 3'd3; wr_val = 32'hDEADBEEF;
      model_edge();
      set_idle();
      ra_sel = 3'd3;
      model_edge();
      total++;
      if (ra !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL write_read: ra=%h, required deadbeef", ra);
      end
   endtask

   task automatic test_bypass();
      set_idle();
      ra_sel = 3'd5; rb_sel = 3'd5;
      wr_en = 1'b1; rd_sel = 3'd5; wr_val = 32'h11;
      model_edge();
      total++;
      if (ra !== 32'h11 || rb !== 32'h11) begin
         bad++;
         $display("FAIL bypass_first: ra=%h rb=%h, required 11 11", ra, rb);
      end
      wr_val = 32'h22;
      model_edge();
      total++;
      if (ra !== 32'h22 || rb !== 32'h22) begin
         bad++;
         $display("FAIL bypass_second: ra=%h rb=%h, required 22 22", ra, rb);
      end
      set_idle();
      model_edge();
   endtask

   task automatic test_debug();
      set_idle();
      dbg_req = 1'b1; dbg_wr = 1'b1; dbg_sel = 3'd2; dbg_wr_val = 32'hCAFEF00D;
      model_edge();
      total++;
      if (dbg_ack !== 1'b1) begin
         bad++;
         $display("FAIL dbg_write_ack: ack=%b, required 1", dbg_ack);
      end
      set_idle();
      model_edge();
      total++;
      if (dbg_ack !== 1'b0) begin
         bad++;
         $display("FAIL dbg_ack_pulse: ack=%b, required 0", dbg_ack);
      end
      dbg_req = 1'b1; dbg_wr = 1'b0; dbg_sel = 3'd2; rb_sel = 3'd2;
      model_edge();
      total++;
      if (dbg_ack !== 1'b1 || dbg_rd_val !== 32'hCAFEF00D || rb !== 32'hCAFEF00D) begin
         bad++;
         $display("FAIL dbg_read: ack=%b rd=%h rb=%h, required 1 cafef00d cafef00d",
                  dbg_ack, dbg_rd_val, rb);
      end
      set_idle();
      model_edge();
   endtask

   task automatic test_conflict();
      set_idle();
      wr_en = 1'b1; rd_sel = 3'd1; wr_val = 32'hAAAA;
      dbg_req = 1'b1; dbg_wr = 1'b1; dbg_sel = 3'd1; dbg_wr_val = 32'h5555;
      ra_sel = 3'd1;
      model_edge();
      total++;
      if (dbg_ack !== 1'b1 || ra !== 32'hAAAA) begin
         bad++;
         $display("FAIL conflict_edge: ack=%b ra=%h, required 1 0000aaaa", dbg_ack, ra);
      end
      set_idle();
      ra_sel = 3'd1;
      model_edge();
      total++;
      if (ra !== 32'hAAAA) begin
         bad++;
         $display("FAIL conflict_stored: ra=%h, required 0000aaaa", ra);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         if (!(dbg_req && !m_ack)) begin
            dbg_req = ($urandom_range(2) == 0);
            dbg_wr = $urandom_range(1);
            dbg_sel = S'($urandom_range(N - 1));
            dbg_wr_val = $urandom;
         end
         rst = ($urandom_range(79) == 0);
         wr_en = $urandom_range(1);
         rd_sel = ($urandom_range(3) == 0) ? dbg_sel : S'($urandom_range(N - 1));
         wr_val = $urandom;
         ra_sel = S'($urandom_range(N - 1));
         rb_sel = ($urandom_range(3) == 0) ? rd_sel : S'($urandom_range(N - 1));
         model_edge();
         total++;
         if (ra !== m_ra || rb !== m_rb) begin
            bad++;
            $display("FAIL rand_read c=%0d: ra=%h rb=%h, required %h %h", c, ra, rb, m_ra, m_rb);
         end
         total++;
         if (busy !== (m_busy_left > 0) || dbg_ack !== m_ack) begin
            bad++;
            $display("FAIL rand_ctrl c=%0d: busy=%b ack=%b, required %b %b",
                     c, busy, dbg_ack, (m_busy_left > 0), m_ack);
         end
         if (m_rd_valid) begin
            total++;
            if (dbg_rd_val !== m_rd) begin
               bad++;
               $display("FAIL rand_dbg_rd c=%0d: rd=%h, required %h", c, dbg_rd_val, m_rd);
            end
         end
      end
      set_idle();
      while (m_busy_left > 0) model_edge();
      model_edge();
   endtask

   task automatic test_reset_mid_clear();
      int n;
      set_idle();
      dbg_req = 1'b1; dbg_wr = 1'b0; dbg_sel = 3'd4;
      rst = 1'b1;
      model_edge();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) model_edge();
      rst = 1'b1;
      model_edge();
      rst = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         model_edge();
      end
      total++;
      if (n != N) begin
         bad++;
         $display("FAIL midclear_busy: got %0d cycles, required %0d", n, N);
      end
      total++;
      if (dbg_ack !== 1'b0) begin
         bad++;
         $display("FAIL midclear_first_run: ack=%b, required 0", dbg_ack);
      end
      model_edge();
      total++;
      if (dbg_ack !== 1'b1 || dbg_rd_val !== '0) begin
         bad++;
         $display("FAIL midclear_first_ack: ack=%b rd=%h, required 1 0", dbg_ack, dbg_rd_val);
      end
      model_edge();
      total++;
      if (dbg_ack !== 1'b0) begin
         bad++;
         $display("FAIL midclear_spacing: ack=%b, required 0", dbg_ack);
      end
      model_edge();
      total++;
      if (dbg_ack !== 1'b1) begin
         bad++;
         $display("FAIL midclear_second_ack: ack=%b, required 1", dbg_ack);
      end
      set_idle();
      model_edge();
   endtask

   task automatic test_sixteen();
      int n;
      sel16 = 4'd15;
      rst16 = 1'b1;
      @(posedge clk); #1;
      rst16 = 1'b0;
      n = 0;
      while (busy16 === 1'b1 && n < 100) begin
         n++;
         @(posedge clk); #1;
      end
      total++;
      if (n != 16) begin
         bad++;
         $display("FAIL sixteen_busy: got %0d cycles, required 16", n);
      end
      @(posedge clk); #1;
      total++;
      if (ra16 !== '0 || ack16 !== 1'b0) begin
         bad++;
         $display("FAIL sixteen_read: ra=%h ack=%b, required 0 0", ra16, ack16);
      end
   endtask

   initial begin
      set_idle();
      rst16 = 1'b1; sel16 = '0;
      m_busy_left = N; m_ack = 0; m_rd_valid = 0;
      for (int i = 0; i < N; i++) m_mem[i] = 'x;
      #2;
      test_reset();
      test_write_read();
      test_bypass();
      test_debug();
      test_conflict();
      test_random();
      test_reset_mid_clear();
      test_sixteen();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
